rgb_led_controller: RTL and testbench
=====================================

# rgb_led_controller

Command parser and PWM driver sitting directly downstream of the UART receive FIFO. It pops received bytes, echoes each one back through the UART transmitter, and parses short ASCII commands such as `r1\n` (toggle) and `g2A0\n` (set level). The parsed commands set nine 8-bit brightness levels: three RGB LEDs with three colours each. It then drives the nine LED outputs with glitch-free PWM.

## Interface
- `DEFAULT_LEVEL`, 8'h11: level applied when a toggle turns a channel on.
- `PWM_PRESCALE`, 1: clocks per PWM counter step (≥1); PWM period = 256·PWM_PRESCALE clocks.
- `ECHO`, 1: 1 = echo every consumed byte to the UART TX; 0 = never assert `o_Start`.
- One clock; reset is asynchronous and active-high.
- `i_Clock` in 1: system clock.
- `i_Reset` in 1: async active-high reset.
- `i_Data_Ready` in 1: UART RX FIFO not empty.
- `i_Data` in 8: FIFO head byte, valid while `i_Data_Ready`.
- `o_Read_Data` out 1: one-cycle FIFO pop strobe.
- `i_Busy_TX` in 1: UART transmitter busy.
- `o_Start` out 1: one-cycle TX start strobe.
- `o_TX_Data` out 8: byte to transmit, valid with `o_Start`.
- `o_LED_R`, `o_LED_G`, `o_LED_B` out 3 each: PWM outputs; bit k = LED k+1, active-high.
- `o_Cmd_Done` out 1: one-cycle pulse when a command is applied.
- `o_Cmd_Error` out 1: one-cycle pulse when a byte is rejected.

## Operation
- Fetch FSM with two states.
  - WAIT: if `i_Data_Ready` && (~`i_Busy_TX` || ECHO==0), register the following: `o_Read_Data`=1; `o_Start`=ECHO; `o_TX_Data`=`i_Data`; parse `i_Data`. Then go to PAUSE.
  - PAUSE: clear the strobes and return to WAIT. This gives the FIFO flag one cycle to update.
- Parse state (advanced only on consumed bytes):
  - P_COLOUR: 0x72 'r', 0x67 'g' or 0x62 'b' latches the colour → P_NUMBER.
  - P_NUMBER: 0x31–0x33 latches LED index 0–2 → P_ARG.
  - P_ARG: 0x0A → toggle the selected level. If it is nonzero it becomes 0; otherwise it becomes DEFAULT_LEVEL. Pulse Done → P_COLOUR. A hex digit latches the high nibble → P_LO.
  - P_LO: a hex digit latches the low nibble → P_END.
  - P_END: 0x0A writes {hi,lo} to the selected level. Pulse Done → P_COLOUR.
- Hex digits accepted: 0x30–0x39, 0x41–0x46, 0x61–0x66.
- 0x0D is consumed, echoed and ignored in every parse state (no state change, no error).
- Any other byte, in any state: pulse Error, discard the partial command, return to P_COLOUR. The byte is still echoed. A bad byte is never reinterpreted as the start of a new command.
- PWM:
  - A shared prescaler counts 0..PWM_PRESCALE-1; the 8-bit counter `cnt` increments on prescaler wrap.
  - Each output = (cnt < shadow_level). Level 0 → constant 0; 0xFF → high 255 of 256 steps.
  - Shadow levels copy the working levels only at a period boundary: the cycle where cnt goes 0xFF→0x00. This makes level changes glitch-free.

## Timing
- Reset values:
  - FSM WAIT, parse P_COLOUR.
  - All working and shadow levels 0; prescaler and cnt 0.
  - Every output 0, including `o_TX_Data`.
- Handshake:
  - Condition sampled at edge N → `o_Read_Data`, `o_Start`, `o_TX_Data` and any Done/Error pulse are high for exactly the cycle after edge N.
  - Next pop is no earlier than edge N+2: at most one byte per 2 clocks.
- The working level updates at the same edge that raises `o_Cmd_Done`. The change reaches the pins at the next period boundary: latency ≤ 256·PWM_PRESCALE+1 clocks.
- With ECHO=1 and `i_Busy_TX` high, no pop happens. The byte waits in the FIFO with no loss, and the parse state holds.
- A write and a shadow load in the same cycle: the shadow takes the old value and the new value appears one period later.
- `i_Reset` mid-command or mid-period: immediate return to reset values, and the partial command is lost.

## Test plan
- Reset, then "r1\n" at 115200 baud: three pops and three echoes of 0x72, 0x31, 0x0A. Done pulses on the third pop. Red level of LED 1 = 0x11, so `o_LED_R[0]` is high for 17 of every 256 clocks from the next boundary.
- Repeat "r1\n": level returns to 0 and `o_LED_R[0]` stays low.
- "b3A0\r\n": blue level of LED 3 = 0xA0 and `o_LED_B[2]` is high for 160 of 256 clocks. Six echoes, one Done, no Error.
- "x" then "g2\n": Error on 'x' and 'x' is echoed. Green level of LED 2 = 0x11. "r4\n" errors on '4', then '\n' errors in P_COLOUR; no level changes.
- Hold `i_Busy_TX`=1 for 2000 clocks with the FIFO ready: no `o_Read_Data`. Release: the pop happens on the next clock, and pops are spaced ≥2 clocks apart.
- Write 0xFF at mid-period, then reset mid-command: the output does not change until the boundary. After reset all outputs are 0 and "g1\n" works normally.

Source files
------------

// File: rtl/rgb_led_controller_if.sv
// rgb_led_controller_if: UART RX FIFO pop and UART TX start handshake bundle
interface rgb_led_controller_if;
  logic       i_Data_Ready;
  logic [7:0] i_Data;
  logic       o_Read_Data;
  logic       i_Busy_TX;
  logic       o_Start;
  logic [7:0] o_TX_Data;
  modport master (
    output i_Data_Ready, i_Data, i_Busy_TX,
    input  o_Read_Data, o_Start, o_TX_Data
  );
  modport slave (
    input  i_Data_Ready, i_Data, i_Busy_TX,
    output o_Read_Data, o_Start, o_TX_Data
  );
endinterface

// File: rtl/rgb_led_controller.sv
// rgb_led_controller: ASCII command parser with echo feeding nine shadowed PWM channels
module rgb_led_controller #(
  parameter logic [7:0] DEFAULT_LEVEL = 8'h11,
  parameter int         PWM_PRESCALE  = 1,
  parameter bit         ECHO          = 1'b1
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  rgb_led_controller_if.slave        bus,
  output logic [2:0]                 o_LED_R,
  output logic [2:0]                 o_LED_G,
  output logic [2:0]                 o_LED_B,
  output logic                       o_Cmd_Done,
  output logic                       o_Cmd_Error
);
  typedef enum logic {WAIT, PAUSE} fetch_t;
  typedef enum logic [2:0] {P_COLOUR, P_NUMBER, P_ARG, P_LO, P_END} parse_t;
  localparam int PW = PWM_PRESCALE > 1 ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PWM_PRESCALE - 1);
  fetch_t fetch;
  parse_t parse, parse_nx;
  logic [1:0] col, led, col_nx, led_nx;
  logic [3:0] hi, lo, hex, sel;
  logic [7:0] lvl [0:8];
  logic [7:0] shd [0:8];
  logic [PW-1:0] pre;
  logic [7:0] cnt, d;
  logic [8:0] pwm;
  logic take, acc, ok, fin, is_hex, is_col, is_num, is_cr, is_lf, done_nx, err_nx, tick, wrap;
  // Byte classification and next parse state for the byte at the FIFO head
  always_comb begin
    d = bus.i_Data;
    take = fetch == WAIT && bus.i_Data_Ready && (!bus.i_Busy_TX || !ECHO);
    is_cr = d == 8'h0D;
    is_lf = d == 8'h0A;
    is_hex = (d >= 8'h30 && d <= 8'h39) || (d >= 8'h41 && d <= 8'h46) || (d >= 8'h61 && d <= 8'h66);
    hex = d <= 8'h39 ? d[3:0] : d[3:0] + 4'd9;
    is_col = d == 8'h72 || d == 8'h67 || d == 8'h62;
    col_nx = d == 8'h72 ? 2'd0 : d == 8'h67 ? 2'd1 : 2'd2;
    is_num = d >= 8'h31 && d <= 8'h33;
    led_nx = d[1:0] - 2'd1;
    ok = 1'b0;
    fin = 1'b0;
    parse_nx = P_COLOUR;
    case (parse)
      P_COLOUR: begin ok = is_col; parse_nx = P_NUMBER; end
      P_NUMBER: begin ok = is_num; parse_nx = P_ARG; end
      P_ARG:    begin ok = is_lf || is_hex; fin = is_lf; parse_nx = is_lf ? P_COLOUR : P_LO; end
      P_LO:     begin ok = is_hex; parse_nx = P_END; end
      P_END:    begin ok = is_lf; fin = 1'b1; parse_nx = P_COLOUR; end
      default:  begin ok = 1'b0; parse_nx = P_COLOUR; end
    endcase
    acc = take && !is_cr;
    done_nx = acc && ok && fin;
    err_nx = acc && !ok;
    sel = {2'b00, col} * 4'd3 + {2'b00, led};
    tick = pre == PRE_MAX;
    wrap = tick && cnt == 8'hFF;
  end
  // Fetch FSM: pop one byte, then pause a cycle so the FIFO flag can settle
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      fetch <= WAIT;
      bus.o_Read_Data <= 1'b0;
      bus.o_Start <= 1'b0;
      bus.o_TX_Data <= 8'h00;
      o_Cmd_Done <= 1'b0;
      o_Cmd_Error <= 1'b0;
    end else begin
      fetch <= take ? PAUSE : WAIT;
      bus.o_Read_Data <= take;
      bus.o_Start <= take && ECHO;
      if (take) bus.o_TX_Data <= d;
      o_Cmd_Done <= done_nx;
      o_Cmd_Error <= err_nx;
    end
  end
  // Parser: advances only on consumed non-CR bytes; any rejection restarts at the colour
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      parse <= P_COLOUR;
      col <= 2'd0;
      led <= 2'd0;
      hi <= 4'd0;
      lo <= 4'd0;
    end else if (acc) begin
      parse <= ok ? parse_nx : P_COLOUR;
      if (ok && parse == P_COLOUR) col <= col_nx;
      if (ok && parse == P_NUMBER) led <= led_nx;
      if (ok && parse == P_ARG) hi <= hex;
      if (ok && parse == P_LO) lo <= hex;
    end
  end
  // Working levels: toggle on "<c><n>\n", direct write on "<c><n><h><h>\n"
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < 9; i++) lvl[i] <= 8'h00;
    end else if (done_nx) begin
      lvl[sel] <= parse == P_ARG ? (|lvl[sel] ? 8'h00 : DEFAULT_LEVEL) : {hi, lo};
    end
  end
  // PWM timebase; shadows reload only as cnt wraps so a period is never cut short
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pre <= '0;
      cnt <= 8'h00;
      pwm <= 9'h000;
      for (int i = 0; i < 9; i++) shd[i] <= 8'h00;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      cnt <= cnt + {7'd0, tick};
      for (int i = 0; i < 9; i++) begin
        if (wrap) shd[i] <= lvl[i];
        pwm[i] <= cnt < shd[i];
      end
    end
  end
  assign o_LED_R = pwm[2:0];
  assign o_LED_G = pwm[5:3];
  assign o_LED_B = pwm[8:6];
endmodule

// File: tb/tb_rgb_led_controller.sv
// tb_rgb_led_controller: table-driven command checks with an echo scoreboard and PWM duty measurement
module tb_rgb_led_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rgb_led_controller_if bus();
  logic [2:0] led_r, led_g, led_b;
  logic done, err;
  rgb_led_controller #(.DEFAULT_LEVEL(8'h11), .PWM_PRESCALE(1), .ECHO(1'b1)) dut (
    .i_Clock(clk), .i_Reset(rst), .bus(bus),
    .o_LED_R(led_r), .o_LED_G(led_g), .o_LED_B(led_b),
    .o_Cmd_Done(done), .o_Cmd_Error(err)
  );
  typedef logic [7:0] u8;
  typedef struct { string cmd; int ch; int lvl; int dn; int er; } vec_t;
  vec_t tbl [11];
  u8 fifo[$];
  u8 sb[$];
  int checks = 0, errors = 0, cyc = 0, last_pop = -10, n_pop = 0, n_done = 0, n_err = 0;
  int m [9];
  int hi_cnt [9];
  bit meas = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function void drive();
    bus.i_Data_Ready = fifo.size() != 0;
    bus.i_Data = fifo.size() != 0 ? fifo[0] : 8'h00;
  endfunction

  task automatic tick();
    logic [8:0] l;
    @(negedge clk);
    cyc++;
    if (bus.o_Read_Data) begin
      chk("pop_spacing", int'(cyc - last_pop >= 2), 1);
      chk("start_with_pop", int'(bus.o_Start), 1);
      if (sb.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("echo_byte", int'(bus.o_TX_Data), int'(sb.pop_front()));
      if (fifo.size() != 0) void'(fifo.pop_front());
      last_pop = cyc;
      n_pop++;
    end else if (bus.o_Start) chk("start_without_pop", 1, 0);
    n_done += int'(done);
    n_err += int'(err);
    l = {led_b, led_g, led_r};
    if (meas) for (int i = 0; i < 9; i++) hi_cnt[i] += int'(l[i]);
    drive();
  endtask

  task automatic push_str(string s);
    for (int i = 0; i < s.len(); i++) begin
      fifo.push_back(s[i]);
      sb.push_back(s[i]);
    end
    drive();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fifo.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", fifo.size(), 0);
    repeat (4) tick();
  endtask

  task automatic measure(string tag);
    repeat (260) tick();
    for (int i = 0; i < 9; i++) hi_cnt[i] = 0;
    meas = 1;
    repeat (256) tick();
    meas = 0;
    for (int i = 0; i < 9; i++) chk($sformatf("%s_duty_ch%0d", tag, i), hi_cnt[i], m[i]);
  endtask

  task automatic sync_period(output bit ok, output int r0_hi);
    bit prev = led_b[2];
    ok = 0;
    r0_hi = 0;
    for (int n = 0; n < 600 && !ok; n++) begin
      tick();
      ok = !prev && led_b[2];
      prev = led_b[2];
      if (!ok) r0_hi += int'(led_r[0]);
    end
  endtask

  initial begin
    int d0, e0, p0, bad, r0;
    bit ok;
    bus.i_Busy_TX = 1'b0;
    bus.i_Data_Ready = 1'b0;
    bus.i_Data = 8'h00;
    for (int i = 0; i < 9; i++) m[i] = 0;
    tbl[0]  = '{"r1\n", 0, 'h11, 1, 0};
    tbl[1]  = '{"r1\n", 0, 'h00, 1, 0};
    tbl[2]  = '{"b3A0\r\n", 8, 'hA0, 1, 0};
    tbl[3]  = '{"x", -1, 0, 0, 1};
    tbl[4]  = '{"g2\n", 4, 'h11, 1, 0};
    tbl[5]  = '{"r4\n", -1, 0, 0, 2};
    tbl[6]  = '{"g2ff\n", 4, 'hFF, 1, 0};
    tbl[7]  = '{"b1\rc\n", -1, 0, 0, 1};
    tbl[8]  = '{"r3gg1\n", 3, 'h11, 1, 1};
    tbl[9]  = '{"B1\n", -1, 0, 0, 3};
    tbl[10] = '{"\rb1\r5\r5\r\n", 6, 'h55, 1, 0};
    repeat (3) tick();
    chk("rst_leds", int'({led_b, led_g, led_r}), 0);
    chk("rst_tx_data", int'(bus.o_TX_Data), 0);
    chk("rst_strobes", int'({bus.o_Read_Data, bus.o_Start, done, err}), 0);
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 11; i++) begin
      d0 = n_done;
      e0 = n_err;
      p0 = n_pop;
      push_str(tbl[i].cmd);
      wait_idle();
      chk($sformatf("v%0d_pops", i), n_pop - p0, tbl[i].cmd.len());
      chk($sformatf("v%0d_done", i), n_done - d0, tbl[i].dn);
      chk($sformatf("v%0d_error", i), n_err - e0, tbl[i].er);
      if (tbl[i].ch >= 0) m[tbl[i].ch] = tbl[i].lvl;
      measure($sformatf("v%0d", i));
    end
    bus.i_Busy_TX = 1'b1;
    d0 = n_done;
    push_str("r2\n");
    bad = 0;
    repeat (2000) begin
      tick();
      bad += int'(bus.o_Read_Data);
    end
    chk("busy_no_pop", bad, 0);
    chk("busy_fifo_kept", fifo.size(), 3);
    bus.i_Busy_TX = 1'b0;
    tick();
    chk("release_pop_next_clock", int'(bus.o_Read_Data), 1);
    wait_idle();
    chk("busy_cmd_done", n_done - d0, 1);
    m[1] = 'h11;
    measure("busy");
    sync_period(ok, r0);
    chk("sync_first", int'(ok), 1);
    repeat (100) tick();
    push_str("r1FF\n");
    sync_period(ok, r0);
    chk("sync_second", int'(ok), 1);
    chk("no_change_before_boundary", r0, 0);
    chk("change_at_boundary", int'(led_r[0]), 1);
    m[0] = 'hFF;
    push_str("g1");
    wait_idle();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_leds", int'({led_b, led_g, led_r}), 0);
    chk("async_rst_tx_data", int'(bus.o_TX_Data), 0);
    chk("async_rst_strobes", int'({bus.o_Read_Data, bus.o_Start, done, err}), 0);
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) m[i] = 0;
    d0 = n_done;
    e0 = n_err;
    push_str("g1\n");
    wait_idle();
    chk("post_rst_done", n_done - d0, 1);
    chk("post_rst_error", n_err - e0, 0);
    m[3] = 'h11;
    measure("post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
